charge_timer_ctrl: RTL and testbench
====================================

CHARGE_TIMER_CTRL -- requirements
Module: charge_timer_ctrl

Interface
REQ-001 Parameter SEC_PER_COIN, default 30, seconds of charge credited per coin.
REQ-002 Parameter MAX_SEC, default 240 (must be 255 or less), saturation limit of the credited time.
REQ-003 Parameter TICKS_PER_SEC, default 1000, clk cycles per second (clk is the 1 kHz global clock).
REQ-004 Parameter DONE_HOLD, default 2000, clk cycles the DONE state is held.
REQ-005 clk  in  1  global 1 kHz clock, all logic on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 coin_in  in  1  asynchronous coin-sensor level, one rising edge per coin.
REQ-008 start  in  1  asynchronous start-button level.
REQ-009 cancel  in  1  asynchronous cancel-button level.
REQ-010 remain_sec  out  8  credited or remaining seconds.
REQ-011 charging  out  1  high in CHARGING only; drives the charger relay.
REQ-012 done  out  1  high in DONE only.
REQ-013 state  out  2  current state encoding, for display and debug.

Function
REQ-014 Each asynchronous input SHALL pass through a 2-flop synchronizer and a rising-edge detector.
- A rising input edge yields a one-cycle event pulse (coin_ev, start_ev, cancel_ev) 3 clk edges later.
REQ-015 States: IDLE=0, PAID=1, CHARGING=2, DONE=3.
REQ-016 IDLE: coin_ev -> PAID, remain_sec=SEC_PER_COIN; start_ev and cancel_ev ignored.
REQ-017 PAID:
- coin_ev adds SEC_PER_COIN, saturating at MAX_SEC.
- start_ev -> CHARGING, ms_cnt cleared to 0.
- cancel_ev -> IDLE, remain_sec=0.
REQ-018 CHARGING, timing:
- ms_cnt counts 0..TICKS_PER_SEC-1 and wraps.
- On the wrap cycle remain_sec decrements by 1.
- If that decrement reaches 0, next state is DONE.
REQ-019 CHARGING, events:
- coin_ev adds SEC_PER_COIN, saturating at MAX_SEC.
- cancel_ev -> IDLE, remain_sec=0.
- start_ev ignored.
REQ-020 Coin and decrement in the same cycle: remain_sec = min(remain_sec + SEC_PER_COIN - 1, MAX_SEC); no DONE transition.
REQ-021 Priority in any state: cancel_ev over coin_ev over start_ev; a coin coinciding with cancel is discarded.
REQ-022 DONE:
- hold_cnt counts DONE_HOLD cycles, then -> IDLE.
- coin_ev -> PAID, remain_sec=SEC_PER_COIN.
- cancel_ev -> IDLE immediately.
REQ-023 Arithmetic: the addition SHALL be computed 9 bits wide before saturation so 8-bit overflow never wraps.
REQ-024 charging, done and state SHALL be registered outputs, changing on the same edge as the state register.
REQ-025 ms_cnt SHALL be 10 bits and hold at 0 outside CHARGING; hold_cnt SHALL be 11 bits and hold at 0 outside DONE.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=IDLE, remain_sec=0, charging=0, done=0;
- ms_cnt=0, hold_cnt=0;
- all synchronizer and edge-detector flops to 0.
REQ-027 Reset asserted mid-CHARGING SHALL open the relay (charging=0) without waiting for a clk edge.
REQ-028 After reset release, an input already held high SHALL NOT produce an event until it falls and rises again.

Structure
REQ-029 Shared package charger_pkg SHALL hold the state encoding typedef and defaults for SEC_PER_COIN, MAX_SEC, TICKS_PER_SEC and DONE_HOLD.
REQ-030 Sub-module edge_sync (2-flop sync plus rising-edge pulse) SHALL be instantiated three times; all other logic stays in charge_timer_ctrl.

Verification
REQ-031 Coin, then start, then wait: coin pulse -> remain_sec=30 after 3 clks; start -> CHARGING; remain_sec=29 after 1000 clks; DONE after 30000 clks; IDLE 2000 clks later.
REQ-032 Saturation: 9 coins in PAID -> remain_sec=240, not 270 and not an 8-bit wrap to 14.
REQ-033 Simultaneous events: in CHARGING, coin_ev on the ms_cnt wrap cycle with remain_sec=1 -> remain_sec=30, state stays CHARGING.
REQ-034 Cancel with coin: cancel_ev and coin_ev on the same cycle in CHARGING with remain_sec=100 -> IDLE, remain_sec=0, charging=0.
REQ-035 Reset mid-charge: rst_n low at remain_sec=50 -> charging=0 asynchronously; start held high through reset release -> no transition.
REQ-036 Coin in DONE: coin at hold_cnt=500 -> PAID, remain_sec=30, done=0.

Source files
------------

// File: rtl/charger_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// charger_pkg: state encoding, parameter defaults and credit arithmetic shared
// by the charge timer. Rev 1.0
// -----------------------------------------------------------------------------
package charger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAID     = 2'd1,
    ST_CHARGING = 2'd2,
    ST_DONE     = 2'd3
  } charger_state_e;

  localparam int SEC_PER_COIN_DEF  = 30;
  localparam int MAX_SEC_DEF       = 240;
  localparam int TICKS_PER_SEC_DEF = 1000;
  localparam int DONE_HOLD_DEF     = 2000;

  // The sum is formed at 9 bits so a credit above 255 clamps rather than wraps.
  function automatic logic [7:0] sat_add(input logic [7:0] base,
                                         input logic [8:0] inc,
                                         input logic [8:0] limit);
    logic [8:0] sum;
    sum = {1'b0, base} + inc;
    return (sum > limit) ? limit[7:0] : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// -----------------------------------------------------------------------------
// edge_sync: two-flop synchronizer with a one-cycle rising-edge pulse. Rev 1.0
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] rdy_q, rdy_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rdy_d   = {rdy_q[0], 1'b1};
    // Arm only after a genuinely low level is seen, so a level held through reset is not an edge.
    armed_d = armed_q | (rdy_q[1] & ~sync2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rdy_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rdy_q   <= rdy_d;
      armed_q <= armed_d;
    end
  end

  assign pulse = armed_q & sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/charge_timer_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// charge_timer_ctrl: coin-credited charger timer with relay and done indication.
// Rev 1.0
// -----------------------------------------------------------------------------
module charge_timer_ctrl
  import charger_pkg::*;
#(
  parameter int SEC_PER_COIN  = SEC_PER_COIN_DEF,
  parameter int MAX_SEC       = MAX_SEC_DEF,
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int DONE_HOLD     = DONE_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       start,
  input  logic       cancel,
  output logic [7:0] remain_sec,
  output logic       charging,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [8:0]  SEC_INC    = 9'(SEC_PER_COIN);
  localparam logic [8:0]  SEC_INC_M1 = 9'(SEC_PER_COIN - 1);
  localparam logic [8:0]  MAX_LIM    = 9'(MAX_SEC);
  localparam logic [7:0]  SEC_INIT   = 8'(SEC_PER_COIN);
  localparam logic [9:0]  MS_LAST    = 10'(TICKS_PER_SEC - 1);
  localparam logic [10:0] HOLD_LAST  = 11'(DONE_HOLD - 1);

  logic [2:0] async_lvl;
  logic [2:0] ev;
  logic       coin_ev, start_ev, cancel_ev;

  assign async_lvl = {cancel, start, coin_in};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (async_lvl[gi]),
      .pulse    (ev[gi])
    );
  end

  assign coin_ev   = ev[0];
  assign start_ev  = ev[1];
  assign cancel_ev = ev[2];

  charger_state_e state_q, state_d;
  logic [7:0]     remain_q, remain_d;
  logic [9:0]     ms_q, ms_d;
  logic [10:0]    hold_q, hold_d;
  logic           charging_q, charging_d;
  logic           done_q, done_d;
  logic           ms_wrap;

  assign ms_wrap = (ms_q == MS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      ms_q       <= '0;
      hold_q     <= '0;
      charging_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      ms_q       <= ms_d;
      hold_q     <= hold_d;
      charging_q <= charging_d;
      done_q     <= done_d;
    end
  end

  // Counters default to zero so they rest at 0 in every state that does not own them.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ms_d     = '0;
    hold_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (coin_ev && !cancel_ev) begin
          state_d  = ST_PAID;
          remain_d = SEC_INIT;
        end
      end
      ST_PAID: begin
        if (cancel_ev) begin
          state_d  = ST_IDLE;
          remain_d = '0;
        end else if (coin_ev) begin
          remain_d = sat_add(remain_q, SEC_INC, MAX_LIM);
        end else if (start_ev) begin
          state_d = ST_CHARGING;
        end
      end
      ST_CHARGING: begin
        ms_d = ms_wrap ? '0 : ms_q + 10'd1;
        if (cancel_ev) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          ms_d     = '0;
        end else if (coin_ev) begin
          // A coin landing on the second boundary absorbs that second's decrement.
          remain_d = ms_wrap ? sat_add(remain_q, SEC_INC_M1, MAX_LIM)
                             : sat_add(remain_q, SEC_INC, MAX_LIM);
        end else if (ms_wrap) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = ST_DONE;
            ms_d    = '0;
          end
        end
      end
      ST_DONE: begin
        hold_d = hold_q + 11'd1;
        if (cancel_ev) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          hold_d   = '0;
        end else if (coin_ev) begin
          state_d  = ST_PAID;
          remain_d = SEC_INIT;
          hold_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          hold_d   = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = '0;
      end
    endcase
  end

  always_comb begin
    charging_d = (state_d == ST_CHARGING);
    done_d     = (state_d == ST_DONE);
  end

  assign remain_sec = remain_q;
  assign charging   = charging_q;
  assign done       = done_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_charge_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_charge_timer_ctrl: bench for the charge timer, one full-rate instance and
// one with a short second for the model-checked scenarios. Rev 1.0
// -----------------------------------------------------------------------------
module tb_charge_timer_ctrl;

  localparam int SEC  = 30;
  localparam int MAXS = 240;
  localparam int HOLD = 2000;
  localparam int MT   = 1000;
  localparam int FT   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic coin_m = 1'b0, start_m = 1'b0, cancel_m = 1'b0;
  logic coin_f = 1'b0, start_f = 1'b0, cancel_f = 1'b0;
  logic [7:0] remain_m, remain_f;
  logic       charging_m, done_m, charging_f, done_f;
  logic [1:0] state_m, state_f;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  charge_timer_ctrl #(.SEC_PER_COIN(SEC), .MAX_SEC(MAXS), .TICKS_PER_SEC(MT), .DONE_HOLD(HOLD)) dut_m (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_m), .start(start_m), .cancel(cancel_m),
    .remain_sec(remain_m), .charging(charging_m), .done(done_m), .state(state_m));

  charge_timer_ctrl #(.SEC_PER_COIN(SEC), .MAX_SEC(MAXS), .TICKS_PER_SEC(FT), .DONE_HOLD(HOLD)) dut_f (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_f), .start(start_f), .cancel(cancel_f),
    .remain_sec(remain_f), .charging(charging_f), .done(done_f), .state(state_f));

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      if (failures >= 50) finish_tb();
    end
  endtask

  // Reference model of the short-second instance: credit in seconds, elapsed
  // charge time in clk cycles, age of the done display in clk cycles.
  int m_state = 0, m_remain = 0, m_tick = 0, m_age = 0, m_n = 0;
  logic [3:0] hc = 4'b0, hs = 4'b0, hx = 4'b0;
  bit ce, se, xe, sec_b;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_remain = 0; m_tick = 0; m_age = 0; m_n = 0;
      hc = 4'b0; hs = 4'b0; hx = 4'b0;
    end else begin
      m_n++;
      hc = {hc[2:0], coin_f};
      hs = {hs[2:0], start_f};
      hx = {hx[2:0], cancel_f};
      // A rise between two post-reset samples is acted on two samples later.
      ce = (m_n >= 4) && hc[2] && !hc[3];
      se = (m_n >= 4) && hs[2] && !hs[3];
      xe = (m_n >= 4) && hx[2] && !hx[3];
      case (m_state)
        0: if (!xe && ce) begin m_state = 1; m_remain = SEC; end
        1: begin
          if (xe) begin m_state = 0; m_remain = 0; end
          else if (ce) m_remain = min_i(m_remain + SEC, MAXS);
          else if (se) begin m_state = 2; m_tick = 0; end
        end
        2: begin
          m_tick++;
          sec_b = (m_tick % FT) == 0;
          if (xe) begin m_state = 0; m_remain = 0; end
          else if (ce && sec_b) m_remain = min_i(m_remain + SEC - 1, MAXS);
          else if (ce) m_remain = min_i(m_remain + SEC, MAXS);
          else if (sec_b) begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin m_state = 3; m_age = 0; end
          end
        end
        default: begin
          m_age++;
          if (xe) begin m_state = 0; m_remain = 0; end
          else if (ce) begin m_state = 1; m_remain = SEC; end
          else if (m_age == HOLD) begin m_state = 0; m_remain = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("lockstep", {20'd0, state_f, remain_f, charging_f, done_f},
            {20'd0, m_state[1:0], m_remain[7:0], m_state == 2, m_state == 3});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 coin, 1 start, 2 cancel
  task automatic drive(input bit fast, input int which, input logic v);
    if (fast) begin
      if (which == 0) coin_f = v; else if (which == 1) start_f = v; else cancel_f = v;
    end else begin
      if (which == 0) coin_m = v; else if (which == 1) start_m = v; else cancel_m = v;
    end
  endtask

  task automatic pulse(input bit fast, input int which);
    drive(fast, which, 1'b1);
    tick(3);
    drive(fast, which, 1'b0);
    tick(2);
  endtask

  initial begin
    #(10 * 95000);
    checks++;
    failures++;
    $display("FAIL watchdog: cycle budget exhausted at %0t", $time);
    finish_tb();
  end

  initial begin
    bit ok;
    int cdiv, sdiv, xdiv;

    tick(3);
    chk_en = 1'b1;
    check("rst_state_m", state_m, 0);
    check("rst_remain_m", remain_m, 0);
    check("rst_charging_m", charging_m, 0);
    check("rst_done_m", done_m, 0);
    rst_n = 1'b1;
    tick(6);

    // Saturation in PAID: eight coins reach the limit, the ninth must clamp.
    for (int i = 0; i < 9; i++) begin
      pulse(1'b0, 0);
      if (i == 7) check("sat_8_coins", remain_m, 240);
    end
    check("sat_9_coins", remain_m, 240);
    check("sat_state", state_m, 1);
    pulse(1'b0, 2);
    check("paid_cancel_state", state_m, 0);
    check("paid_cancel_remain", remain_m, 0);

    // Full-rate coin, start, count down, done, back to idle.
    drive(1'b0, 0, 1'b1);
    tick(3);
    check("coin_remain_30", remain_m, 30);
    check("coin_state_paid", state_m, 1);
    drive(1'b0, 0, 1'b0);
    tick(2);
    drive(1'b0, 1, 1'b1);
    tick(3);
    check("start_state", state_m, 2);
    check("start_relay", charging_m, 1);
    drive(1'b0, 1, 1'b0);
    tick(999);
    check("sec0_remain", remain_m, 30);
    tick(1);
    check("sec1_remain", remain_m, 29);
    tick(28999);
    check("last_sec_remain", remain_m, 1);
    check("last_sec_state", state_m, 2);
    tick(1);
    check("done_state", state_m, 3);
    check("done_flag", done_m, 1);
    check("done_relay_off", charging_m, 0);
    check("done_remain", remain_m, 0);
    tick(1999);
    check("done_hold_state", state_m, 3);
    tick(1);
    check("hold_end_state", state_m, 0);
    check("hold_end_done", done_m, 0);

    // Coin arriving on the second boundary with one second left.
    pulse(1'b1, 0);
    pulse(1'b1, 1);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (m_state == 2 && m_remain == 1 && (m_tick % FT) == 7) ok = 1'b1;
      else tick(1);
    end
    check("wrap_coin_setup", ok, 1);
    check("wrap_coin_pre", remain_f, 1);
    drive(1'b1, 0, 1'b1);
    tick(3);
    check("wrap_coin_remain", remain_f, 30);
    check("wrap_coin_state", state_f, 2);
    drive(1'b1, 0, 1'b0);
    tick(2);

    // Cancel and coin together while charging with 100 s credited.
    for (int i = 0; i < 3; i++) pulse(1'b1, 0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (m_state == 2 && m_remain == 100 && (m_tick % FT) <= 6) ok = 1'b1;
      else tick(1);
    end
    check("cancel_coin_setup", ok, 1);
    check("cancel_coin_pre", remain_f, 100);
    coin_f   = 1'b1;
    cancel_f = 1'b1;
    tick(3);
    check("cancel_coin_state", state_f, 0);
    check("cancel_coin_remain", remain_f, 0);
    check("cancel_coin_relay", charging_f, 0);
    coin_f   = 1'b0;
    cancel_f = 1'b0;
    tick(2);

    // Coin while done is displayed, at hold count 500.
    pulse(1'b1, 0);
    pulse(1'b1, 1);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (m_state == 3 && m_age == 498) ok = 1'b1;
      else tick(1);
    end
    check("done_coin_setup", ok, 1);
    check("done_coin_pre", done_f, 1);
    drive(1'b1, 0, 1'b1);
    tick(3);
    check("done_coin_state", state_f, 1);
    check("done_coin_remain", remain_f, 30);
    check("done_coin_done", done_f, 0);
    drive(1'b1, 0, 1'b0);
    tick(2);
    pulse(1'b1, 2);

    // Reset in mid-charge with start held high through release.
    pulse(1'b1, 0);
    pulse(1'b1, 0);
    pulse(1'b1, 1);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (m_state == 2 && m_remain == 50) ok = 1'b1;
      else tick(1);
    end
    check("reset_setup", ok, 1);
    check("reset_pre_remain", remain_f, 50);
    start_f = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_relay_off", charging_f, 0);
    check("async_state", state_f, 0);
    check("async_remain", remain_f, 0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    pulse(1'b1, 0);
    tick(10);
    check("held_start_ignored", state_f, 1);
    start_f = 1'b0;
    tick(2);
    pulse(1'b1, 1);
    check("fresh_start_state", state_f, 2);
    pulse(1'b1, 2);
    check("charging_cancel_state", state_f, 0);

    // Randomized traffic, checked each cycle against the model.
    for (int seg = 0; seg < 24; seg++) begin
      cdiv = (seg % 3 == 0) ? 15 : ((seg % 3 == 1) ? 80 : 4000);
      sdiv = 25;
      xdiv = (seg % 4 == 3) ? 150 : 100000;
      for (int c = 0; c < 500; c++) begin
        if (($urandom % cdiv) == 0) coin_f = ~coin_f;
        if (($urandom % sdiv) == 0) start_f = ~start_f;
        if (($urandom % xdiv) == 0) cancel_f = ~cancel_f;
        tick(1);
      end
    end
    tick(5);
    finish_tb();
  end

endmodule
`default_nettype wire
